// File: rtl/connect4_board_tracker.sv
// 4x4 Connect-4 board tracker: commits resolved drops to the mover's bitboard,
// then spends one CHECK cycle looking for a four-in-line win or a full-board draw.
module connect4_board_tracker #(
    parameter int CELLS   = 16,
    parameter int WIN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_game,
    input  logic             place_valid,
    input  logic [3:0]       place_pos,
    input  logic             place_invalid,
    output logic             current_player,
    output logic [CELLS-1:0] board_p1,
    output logic [CELLS-1:0] board_p2,
    output logic             move_accept,
    output logic             move_reject,
    output logic [1:0]       winner,
    output logic             draw,
    output logic             game_over
);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    localparam int NUM_LINES = 10;
    // Rows, columns, main diagonal, anti-diagonal.
    localparam logic [NUM_LINES-1:0][CELLS-1:0] LINE_MASK = {
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    state_t           state_q, state_d;
    logic [CELLS-1:0] b1_q, b1_d, b2_q, b2_d;
    logic             cur_q, cur_d;
    logic [1:0]       win_q, win_d;
    logic             draw_q, draw_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             acc_q, acc_d, rej_q, rej_d;

    logic [CELLS-1:0]     occ, pos_bit, mover;
    logic                 supported, illegal;
    logic [NUM_LINES-1:0] line_hit;

    assign occ       = b1_q | b2_q;
    assign pos_bit   = CELLS'(1) << place_pos;
    assign supported = (32'(place_pos) < WIN_LEN) || occ[place_pos - 4'(WIN_LEN)];
    assign illegal   = place_invalid || ((occ & pos_bit) != '0) || !supported;
    assign mover     = cur_q ? b2_q : b1_q;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        assign line_hit[g] = &(mover | ~LINE_MASK[g]);
    end

    always_comb begin
        state_d = state_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        cur_d   = cur_q;
        win_d   = win_q;
        draw_d  = draw_q;
        cnt_d   = cnt_q;
        acc_d   = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            PLAY: begin
                if (place_valid) begin
                    if (illegal) begin
                        rej_d = 1'b1;
                    end else begin
                        if (cur_q) b2_d = b2_q | pos_bit;
                        else       b1_d = b1_q | pos_bit;
                        cnt_d   = cnt_q + 5'd1;
                        acc_d   = 1'b1;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                rej_d = place_valid;
                // A line on the last move wins even when it also fills the board.
                if (|line_hit) begin
                    win_d   = cur_q ? 2'b10 : 2'b01;
                    state_d = OVER;
                end else if (cnt_q == 5'(CELLS)) begin
                    draw_d  = 1'b1;
                    state_d = OVER;
                end else begin
                    cur_d   = ~cur_q;
                    state_d = PLAY;
                end
            end
            default: rej_d = place_valid;
        endcase
        if (new_game) begin
            state_d = PLAY;
            b1_d    = '0;
            b2_d    = '0;
            cur_d   = 1'b0;
            win_d   = 2'b00;
            draw_d  = 1'b0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            rej_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLAY;
            b1_q    <= '0;
            b2_q    <= '0;
            cur_q   <= 1'b0;
            win_q   <= 2'b00;
            draw_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            cur_q   <= cur_d;
            win_q   <= win_d;
            draw_q  <= draw_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rej_q   <= rej_d;
        end
    end

    assign current_player = cur_q;
    assign board_p1       = b1_q;
    assign board_p2       = b2_q;
    assign move_accept    = acc_q;
    assign move_reject    = rej_q;
    assign winner         = win_q;
    assign draw           = draw_q;
    assign game_over      = (win_q != 2'b00) || draw_q;

endmodule
